op_chain_exec: RTL and testbench

OP_CHAIN_EXEC -- requirements
Module: op_chain_exec

---
 rtl/op_chain_pkg.sv | 13 +
 rtl/op_chain_exec_op_alu.sv | 14 +
 rtl/op_chain_exec.sv | 58 +++++
 tb/tb_op_chain_exec.sv | 139 +++++++++++++
 4 files changed

// File: rtl/op_chain_pkg.sv
// op_chain_pkg: shared opcodes, FSM states and counter width for op_chain_exec
package op_chain_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] OP_BUF  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_XOR0 = 3'd2;
  localparam logic [2:0] OP_XOR1 = 3'd3;
  localparam logic [2:0] OP_OR0  = 3'd4;
  localparam logic [2:0] OP_OR1  = 3'd5;
  localparam logic [2:0] OP_AND0 = 3'd6;
  localparam logic [2:0] OP_AND1 = 3'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/op_chain_exec_op_alu.sv
// op_alu: maps (acc, op_code) to the next accumulator bit
module op_alu
  import op_chain_pkg::*;
(
  input  logic       acc,
  input  logic [2:0] op_code,
  output logic       acc_nxt
);
  always_comb begin
    acc_nxt = (op_code == OP_NOT || op_code == OP_XOR1) ? ~acc :
              (op_code == OP_OR1)  ? 1'b1 :
              (op_code == OP_AND0) ? 1'b0 : acc;
  end
endmodule

// File: rtl/op_chain_exec.sv
// op_chain_exec: runs a chain of single-bit ops on a captured operand with valid/ready handshakes
module op_chain_exec
  import op_chain_pkg::*;
#(
  parameter int MAX_OPS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       in_data,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic             op_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_data,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);
  state_t state, state_nxt;
  logic acc, acc_nxt, take, at_max;
  logic [1:0] operand;
  op_alu u_alu (.acc(acc), .op_code(op_code), .acc_nxt(acc_nxt));
  assign take   = op_valid && op_ready;
  assign at_max = op_count == CNT_W'(MAX_OPS - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && take && (op_last || at_max)) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
  end
  always_comb begin
    op_ready  = state == RUN;
    out_valid = state == DONE;
    out_data  = {acc ^ operand[1], acc};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= 1'b0;
      operand  <= 2'b00;
      op_count <= '0;
      err      <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= in_data[0];
      operand  <= in_data;
      op_count <= '0;
      err      <= 1'b0;
    end else if (take) begin
      acc      <= acc_nxt;
      op_count <= op_count + CNT_W'(op_count != '1);
      err      <= !op_last && at_max;
    end
  end
endmodule

// File: tb/tb_op_chain_exec.sv
// tb_op_chain_exec: directed self-checking bench for op_chain_exec (MAX_OPS=4)
module tb_op_chain_exec;
  logic clk = 1'b0;
  logic rst, start, op_valid, op_ready, op_last, out_valid, out_ready, err;
  logic [1:0] in_data, out_data;
  logic [2:0] op_code;
  logic [7:0] op_count;
  int tests = 0;
  int fails = 0;
  op_chain_exec #(.MAX_OPS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_last(op_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .op_count(op_count), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 8'(op_ready), 8'd0);
    chk({tag, "_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_data"}, 8'(out_data), 8'd0);
    chk({tag, "_count"}, op_count, 8'd0);
    chk({tag, "_err"}, 8'(err), 8'd0);
  endtask
  task automatic op(input logic [2:0] code, input logic last);
    op_valid = 1'b1;
    op_code  = code;
    op_last  = last;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; in_data = 2'b00; op_valid = 1'b0;
    op_code = 3'd0; op_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");
    // single NOT chain
    in_data = 2'b10; start = 1'b1; tick(); start = 1'b0;
    chk("t1_run_ready", 8'(op_ready), 8'd1);
    chk("t1_run_valid", 8'(out_valid), 8'd0);
    op(3'd1, 1'b1); tick(); op_valid = 1'b0;
    chk("t1_valid", 8'(out_valid), 8'd1);
    chk("t1_ready", 8'(op_ready), 8'd0);
    chk("t1_data", 8'(out_data), 8'h01);
    chk("t1_count", op_count, 8'd1);
    chk("t1_err", 8'(err), 8'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_idle_valid", 8'(out_valid), 8'd0);
    chk("t1_idle_count", op_count, 8'd1);
    chk("t1_idle_data", 8'(out_data), 8'h01);
    // back-to-back XOR1, AND1, OR0
    in_data = 2'b01; start = 1'b1; tick(); start = 1'b0;
    op(3'd3, 1'b0); tick();
    chk("t2_ready1", 8'(op_ready), 8'd1);
    chk("t2_count1", op_count, 8'd1);
    op(3'd7, 1'b0); tick();
    chk("t2_ready2", 8'(op_ready), 8'd1);
    chk("t2_count2", op_count, 8'd2);
    op(3'd4, 1'b1); tick(); op_valid = 1'b0;
    chk("t2_valid", 8'(out_valid), 8'd1);
    chk("t2_data", 8'(out_data), 8'h00);
    chk("t2_count", op_count, 8'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    // gaps and consumer backpressure
    in_data = 2'b11; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t3_gap0", op_count, 8'd0);
    op(3'd1, 1'b0); tick(); op_valid = 1'b0;
    tick();
    chk("t3_gap1", op_count, 8'd1);
    op(3'd5, 1'b1); tick(); op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", 8'(out_valid), 8'd1);
      chk("t3_hold_data", 8'(out_data), 8'h01);
      op(3'd6, 1'b0);
      tick();
      op_valid = 1'b0;
      chk("t3_hold_count", op_count, 8'd2);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t3_idle_valid", 8'(out_valid), 8'd0);
    chk("t3_idle_ready", 8'(op_ready), 8'd0);
    chk("t3_idle_data", 8'(out_data), 8'h01);
    // truncation at MAX_OPS=4
    in_data = 2'b00; start = 1'b1; tick(); start = 1'b0;
    op(3'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_err_early", 8'(err), 8'd0);
    end
    tick();
    chk("t4_ready", 8'(op_ready), 8'd0);
    chk("t4_valid", 8'(out_valid), 8'd1);
    chk("t4_err", 8'(err), 8'd1);
    chk("t4_count", op_count, 8'd4);
    tick();
    chk("t4_fifth_count", op_count, 8'd4);
    chk("t4_fifth_data", 8'(out_data), 8'h00);
    op_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_idle_err", 8'(err), 8'd1);
    chk("t4_idle_count", op_count, 8'd4);
    // reset mid-RUN, then clean chain
    in_data = 2'b10; start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_err", 8'(err), 8'd0);
    chk("t5_start_count", op_count, 8'd0);
    op(3'd1, 1'b0); tick(); tick();
    chk("t5_pre_count", op_count, 8'd2);
    rst = 1'b1; start = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; op_valid = 1'b0;
    chk_reset("t5_rst");
    in_data = 2'b10; start = 1'b1; tick(); start = 1'b0;
    op(3'd1, 1'b1); tick(); op_valid = 1'b0;
    chk("t5_valid", 8'(out_valid), 8'd1);
    chk("t5_data", 8'(out_data), 8'h01);
    chk("t5_count", op_count, 8'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    // start ignored while running
    in_data = 2'b10; start = 1'b1; tick();
    in_data = 2'b01;
    op(3'd1, 1'b0); tick(); start = 1'b0;
    op(3'd0, 1'b1); tick(); op_valid = 1'b0;
    chk("t6_valid", 8'(out_valid), 8'd1);
    chk("t6_data", 8'(out_data), 8'h01);
    chk("t6_count", op_count, 8'd2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t6_idle_valid", 8'(out_valid), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
